// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one 16-bit ALU between NUM_REQ requesters, with a registered tagged response.
// Optional multiplier for opcode 2 is built when ALU_RR_SCHED_MUL_EN is defined.
module alu_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_op,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [15:0]             rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_err,
  output logic [15:0]             op_cnt
);

  logic              rsp_valid_q, rsp_valid_d;
  logic [15:0]       rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic              rsp_err_q, rsp_err_d;
  logic [15:0]       op_cnt_q, op_cnt_d;
  logic [ID_W-1:0]   last_gnt_q, last_gnt_d;

  logic [NUM_REQ-1:0] win;
  logic [ID_W-1:0]    win_id;
  logic [3:0]         win_op;
  logic [15:0]        win_a, win_b;
  logic               found;
  logic               slot_free;
  logic               accept;
  logic [16:0]        alu_res;

  // Returns {err, data}; opcodes outside the legal set yield zero data with err set.
  function automatic logic [16:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [15:0] r;
    logic        e;
    r = '0;
    e = 1'b0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
`ifdef ALU_RR_SCHED_MUL_EN
      4'd2:  r = a * b;
`else
      4'd2:  e = 1'b1;
`endif
      4'd3:  r = a;
      4'd4:  r = b;
      4'd5:  r = a & b;
      4'd6:  r = a | b;
      4'd7:  r = a ^ b;
      4'd8:  r = ~a;
      4'd9:  r = ~b;
      4'd10: r = {1'b0, a[15:1]};
      4'd11: r = {a[14:0], 1'b0};
      default: e = 1'b1;
    endcase
    return {e, r};
  endfunction

  // Scan from the requester after the last grant, wrapping, and pick the first valid one.
  always_comb begin
    win    = '0;
    win_id = '0;
    win_op = '0;
    win_a  = '0;
    win_b  = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(last_gnt_q) + 1 + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        win_id   = ID_W'(idx);
        win_op   = req_op[4*idx +: 4];
        win_a    = req_a[16*idx +: 16];
        win_b    = req_b[16*idx +: 16];
      end
    end
  end

  assign slot_free = !rsp_valid_q || rsp_ready;
  assign req_ready = win & {NUM_REQ{slot_free}};
  assign accept    = found && slot_free;
  assign alu_res   = alu_fn(win_op, win_a, win_b);

  // A new accept overwrites a result that drains in the same cycle, keeping 1 op/cycle.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    op_cnt_d    = op_cnt_q;
    last_gnt_d  = last_gnt_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = alu_res[15:0];
      rsp_err_d   = alu_res[16];
      rsp_id_d    = win_id;
      last_gnt_d  = win_id;
      op_cnt_d    = op_cnt_q + 16'd1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      op_cnt_q    <= '0;
      last_gnt_q  <= ID_W'(NUM_REQ - 1);
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      op_cnt_q    <= op_cnt_d;
      last_gnt_q  <= last_gnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Bench for alu_rr_sched: reference arbiter/ALU model feeding a result scoreboard, plus directed checks.
module tb_alu_rr_sched;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [4*NUM_REQ-1:0]  req_op;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [15:0]           rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_err;
  logic [15:0]           op_cnt;

  alu_rr_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            err;
    logic [ID_W-1:0] id;
    logic [15:0]     data;
  } rsp_t;

  rsp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic        m_valid;
  logic [15:0] m_cnt;
  int          m_last;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [16:0] ref_alu(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [31:0] p;
    case (op)
      4'd0:  return {1'b0, 16'(a + b)};
      4'd1:  return {1'b0, 16'(a - b)};
`ifdef ALU_RR_SCHED_MUL_EN
      4'd2:  begin p = a * b; return {1'b0, p[15:0]}; end
`endif
      4'd3:  return {1'b0, a};
      4'd4:  return {1'b0, b};
      4'd5:  return {1'b0, a & b};
      4'd6:  return {1'b0, a | b};
      4'd7:  return {1'b0, a ^ b};
      4'd8:  return {1'b0, ~a};
      4'd9:  return {1'b0, ~b};
      4'd10: return {1'b0, a >> 1};
      4'd11: return {1'b0, 16'(a << 1)};
      default: return {1'b1, 16'h0000};
    endcase
  endfunction

  // Reference model, advanced once per cycle on the falling edge while inputs are stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_valid = 1'b0;
      m_cnt   = 16'd0;
      m_last  = NUM_REQ - 1;
    end else begin
      int          w;
      logic        free;
      logic [3:0]  exp_rdy;
      logic [16:0] r;
      rsp_t        e;
      chk("mon_vld", rsp_valid, m_valid);
      chk("mon_cnt", op_cnt, m_cnt);
      if (m_valid) begin
        if (sb.size() == 0) chk("mon_sb_size", sb.size(), 1);
        else begin
          chk("mon_data", rsp_data, sb[0].data);
          chk("mon_id", rsp_id, sb[0].id);
          chk("mon_err", rsp_err, sb[0].err);
          if (rsp_ready) void'(sb.pop_front());
        end
      end
      free = !m_valid || rsp_ready;
      w = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (m_last + 1 + k) % NUM_REQ;
        if (w < 0 && req_valid[idx]) w = idx;
      end
      exp_rdy = (w >= 0 && free) ? 4'(1 << w) : 4'b0000;
      chk("mon_rdy", req_ready, exp_rdy);
      if (w >= 0 && free) begin
        r = ref_alu(req_op[4*w +: 4], req_a[16*w +: 16], req_b[16*w +: 16]);
        e.err  = r[16];
        e.id   = ID_W'(w);
        e.data = r[15:0];
        sb.push_back(e);
        m_last  = w;
        m_cnt   = m_cnt + 16'd1;
        m_valid = 1'b1;
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b);
    req_op[4*i +: 4]   = op;
    req_a[16*i +: 16]  = a;
    req_b[16*i +: 16]  = b;
  endtask

  task automatic single(input int i, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] ed, input logic ee,
                        input string tag);
    req_valid    = '0;
    req_valid[i] = 1'b1;
    set_req(i, op, a, b);
    rsp_ready    = 1'b1;
    at_neg();
    chk({tag, "_rdy"}, req_ready, 32'(1 << i));
    cyc();
    req_valid = '0;
    at_neg();
    chk({tag, "_data"}, rsp_data, ed);
    chk({tag, "_err"}, rsp_err, ee);
    chk({tag, "_id"}, rsp_id, i);
    cyc();
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n     = 1'b0;
    cyc();
    rst_n     = 1'b1;
  endtask

  int exp_ord[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #12;
    chk("rst_vld", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_cnt", op_cnt, 0);
    chk("rst_rdy", req_ready, 0);
    cyc();
    rst_n = 1'b1;

    // single op from requester 0 straight after reset
    req_valid = 4'b0001;
    set_req(0, 4'd0, 16'h0003, 16'h0004);
    at_neg();
    chk("t1_rdy", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    at_neg();
    chk("t1_vld", rsp_valid, 1);
    chk("t1_data", rsp_data, 16'h0007);
    chk("t1_id", rsp_id, 0);
    chk("t1_err", rsp_err, 0);
    chk("t1_cnt", op_cnt, 1);
    cyc();

    // round robin with every requester asserting
    do_reset();
    set_req(0, 4'd0, 16'h0001, 16'h0002);
    set_req(1, 4'd5, 16'hF0F0, 16'hFF00);
    set_req(2, 4'd7, 16'hAAAA, 16'hFFFF);
    set_req(3, 4'd8, 16'h1234, 16'h0000);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      at_neg();
      chk("rr_rdy", req_ready, 32'(1 << exp_ord[g]));
      if (g > 0) chk("rr_id", rsp_id, exp_ord[g-1]);
      cyc();
    end

    // backpressure: result held, no grants, then resume at last_gnt+1
    rsp_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      at_neg();
      chk("bp_rdy", req_ready, 0);
      chk("bp_id", rsp_id, 0);
      chk("bp_data", rsp_data, 16'h0003);
      chk("bp_cnt", op_cnt, 5);
      cyc();
    end
    rsp_ready = 1'b1;
    at_neg();
    chk("bp_resume_rdy", req_ready, 4'b0010);
    cyc();
    req_valid = '0;
    at_neg();
    chk("bp_resume_id", rsp_id, 1);
    chk("bp_resume_data", rsp_data, 16'hF000);
    cyc();

    // arithmetic boundaries and illegal opcodes
    single(2, 4'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, "sub_wrap");
    single(1, 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, "add_wrap");
    single(3, 4'd10, 16'h8001, 16'h0000, 16'h4000, 1'b0, "shr");
    single(0, 4'd11, 16'h8001, 16'h0000, 16'h0002, 1'b0, "shl");
    single(2, 4'd9, 16'h0000, 16'h00FF, 16'hFF00, 1'b0, "notb");
    single(1, 4'd13, 16'h1234, 16'h5678, 16'h0000, 1'b1, "ill13");
`ifdef ALU_RR_SCHED_MUL_EN
    single(3, 4'd2, 16'h0100, 16'h0100, 16'h0000, 1'b0, "mul");
    single(0, 4'd2, 16'h0012, 16'h0034, 16'h03A8, 1'b0, "mul2");
`else
    single(3, 4'd2, 16'h0100, 16'h0100, 16'h0000, 1'b1, "mul_off");
    single(0, 4'd2, 16'h0012, 16'h0034, 16'h0000, 1'b1, "mul_off2");
`endif

    // async reset while a result is stalled
    req_valid = 4'b1000;
    set_req(3, 4'd3, 16'hBEEF, 16'h0000);
    rsp_ready = 1'b1;
    cyc();
    req_valid = '0;
    rsp_ready = 1'b0;
    at_neg();
    chk("ar_pre_vld", rsp_valid, 1);
    chk("ar_pre_data", rsp_data, 16'hBEEF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_vld", rsp_valid, 0);
    chk("ar_cnt", op_cnt, 0);
    chk("ar_data", rsp_data, 0);
    chk("ar_id", rsp_id, 0);
    cyc();
    cyc();
    set_req(0, 4'd6, 16'h00F0, 16'h000F);
    set_req(3, 4'd3, 16'h1111, 16'h0000);
    req_valid = 4'b1001;
    rsp_ready = 1'b1;
    rst_n     = 1'b1;
    at_neg();
    chk("ar_post_rdy", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    at_neg();
    chk("ar_post_id", rsp_id, 0);
    chk("ar_post_data", rsp_data, 16'h00FF);
    chk("ar_post_cnt", op_cnt, 1);
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
- Shares one 16-bit, 4-bit-opcode ALU between NUM_REQ requesters.
- Uses round-robin arbitration.
- Each requester presents opcode and operands with a valid/ready handshake.
- Each accepted operation produces one registered result, tagged with the requester index, on a single valid/ready response port.
- Sits between the datapath clients and the shared combinational ALU function.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester tag; must be ≥ clog2(NUM_REQ).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous reset, active low
- req_valid  input  NUM_REQ  per-requester operation valid
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero
- req_op  input  4*NUM_REQ  opcode; requester i uses bits [4i+3:4i]
- req_a  input  16*NUM_REQ  operand a; requester i uses bits [16i+15:16i]
- req_b  input  16*NUM_REQ  operand b; same packing as req_a
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  16  result
- rsp_id  output  ID_W  index of the requester that issued the op
- rsp_err  output  1  illegal opcode flag
- op_cnt  output  16  count of accepted operations

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous and active-low on rst_n. Reset values:
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, op_cnt=0.
  - Round-robin pointer last_gnt=NUM_REQ-1, so requester 0 has first priority.
- Slot free condition: slot_free = !rsp_valid || rsp_ready.
- Grant (combinational):
  - Scan requesters starting at last_gnt+1, wrapping modulo NUM_REQ. The first i with req_valid[i] wins.
  - req_ready[i] = win[i] && slot_free. At most one req_ready bit is high per cycle.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Accept occurs on a cycle where some req_valid[i] && req_ready[i]. At the next edge:
  - rsp_data, rsp_id=i and rsp_err are registered.
  - rsp_valid is set to 1.
  - last_gnt is set to i.
  - op_cnt increments, wrapping from 16'hFFFF to 0.
  - Latency is 1 cycle from accept to rsp_valid.
- Drain without refill: rsp_valid && rsp_ready with no accept in the same cycle → rsp_valid clears at the next edge.
- Simultaneous drain and accept: the new result replaces the old one. This sustains full throughput of 1 op/cycle.
- Stall: rsp_valid && !rsp_ready → all req_ready=0. rsp_data, rsp_id and rsp_err hold stable, and last_gnt holds.
- last_gnt changes only on accept. Idle cycles do not rotate priority.
- Opcodes (all results truncated to 16 bits, unsigned):
  - 0 a+b
  - 1 a−b (wraps)
  - 2 a*b (low 16 bits)
  - 3 a
  - 4 b
  - 5 a&b
  - 6 a|b
  - 7 a^b
  - 8 ~a
  - 9 ~b
  - 10 a>>1 (logical, zero-fill)
  - 11 a<<1
- Opcodes 12–15 are still accepted and still consume a grant. They produce rsp_data=0 and rsp_err=1. All legal ops produce rsp_err=0.
- Reset mid-operation: a pending result is discarded, and outputs return to their reset values immediately (asynchronous).

Optional Feature:
- Macro: ALU_RR_SCHED_MUL_EN.
- Defined: opcode 2 is legal and returns the low 16 bits of a*b, rsp_err=0.
- Undefined: no multiplier is built. Opcode 2 is treated as illegal: rsp_data=0, rsp_err=1. It is still accepted, and still counted in op_cnt.

Test Plan:
- Reset then single op: req_valid=4'b0001, op=0, a=16'h0003, b=16'h0004 → req_ready[0]=1. Next cycle rsp_valid=1, rsp_data=16'h0007, rsp_id=0, rsp_err=0, op_cnt=1.
- Round robin: all four req_valid held high, rsp_ready=1 → grant order 0,1,2,3,0 on consecutive cycles, rsp_id follows the same order, and op_cnt reaches 5.
- Backpressure: rsp_valid=1, rsp_ready=0 for 3 cycles → req_ready=0 throughout and rsp_data/rsp_id stable. When rsp_ready rises, the next grant goes to last_gnt+1.
- Arithmetic boundaries:
  - op1 a=0, b=1 → 16'hFFFF.
  - op0 a=16'hFFFF, b=1 → 0.
  - op10 a=16'h8001 → 16'h4000.
  - op11 a=16'h8001 → 16'h0002.
- Illegal/feature: op=13 → rsp_data=0, rsp_err=1. op2 a=16'h0100, b=16'h0100 → rsp_data=0 with ALU_RR_SCHED_MUL_EN defined; rsp_err=1 with it undefined.
- Async reset while rsp_valid=1 and rsp_ready=0 → rsp_valid=0 and op_cnt=0 before the next clock edge. After release, requester 0 wins against requester 3.
